// File: rtl/mem_initiator_pkg.sv
// Shared types for the SRAM bus initiator: access sizes, FSM states, error causes
// and the misalignment rule used by the lane aligner.
package mem_initiator_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'b00,
        MEM_SIZE_H = 2'b01,
        MEM_SIZE_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        MEM_ST_IDLE,
        MEM_ST_BUS,
        MEM_ST_RESP,
        MEM_ST_FAULT
    } mem_state_e;

    typedef enum logic [1:0] {
        MEM_ERR_NONE,
        MEM_ERR_BUS,
        MEM_ERR_MISALIGN,
        MEM_ERR_TIMEOUT
    } mem_err_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] wdata;
    } mem_req_t;

    // Size code 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_SIZE_B: mis = 1'b0;
            MEM_SIZE_H: mis = addr_lo[0];
            default:    mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Core request/response and SRAM bus signals of mem_initiator.
// master = initiator view, slave = core + responder view.
interface mem_initiator_if #(
    parameter int addr_w = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [addr_w-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic              resp_misaligned;

    logic [addr_w-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_b_en;
    logic              mem_w_en;
    logic [31:0]       mem_rdata;
    logic              mem_stall;
    logic              mem_error;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_error, resp_misaligned,
        output mem_addr, mem_wdata, mem_b_en, mem_w_en,
        input  mem_rdata, mem_stall, mem_error
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_error, resp_misaligned,
        input  mem_addr, mem_wdata, mem_b_en, mem_w_en,
        output mem_rdata, mem_stall, mem_error
    );

endinterface

// File: rtl/mem_initiator_lane_align.sv
// Combinational byte-lane logic: byte enables, store replication, load shift/extend,
// plus misalignment check of an incoming request.
module mem_lane_align
    import mem_initiator_pkg::*;
(
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_addr_lo,
    output logic        chk_misaligned,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  b_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_fmt
);

    logic [31:0] shifted;

    assign chk_misaligned = is_misaligned(chk_size, chk_addr_lo);
    assign shifted        = rdata >> {addr_lo, 3'b000};

    always_comb begin
        b_en      = '0;
        wdata_rep = '0;
        rdata_fmt = '0;
        case (size)
            MEM_SIZE_B: begin
                b_en      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_fmt = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            MEM_SIZE_H: begin
                b_en      = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_fmt = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                b_en      = 4'b1111;
                wdata_rep = wdata;
                rdata_fmt = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// SRAM bus initiator: IDLE -> BUS -> RESP (or IDLE -> FAULT) per core load/store.
// Optional stall timeout enabled by defining RVM_MEM_TIMEOUT_EN.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int addr_w         = 32,
    parameter int data_w         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             gclk,
    input logic             resetn,
    mem_initiator_if.master bus
);

    if (data_w != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_initiator: data_w must be 32 and TIMEOUT_CYCLES at least 1");
    end

    mem_state_e        state, state_next;
    mem_err_e          err_q, err_next;
    mem_req_t          req_q;
    logic [addr_w-1:0] addr_q;
    logic              accept;
    logic              chk_misaligned;
    logic              to_hit;
    logic [3:0]        b_en;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_fmt;

    mem_lane_align u_align (
        .chk_size       (bus.req_size),
        .chk_addr_lo    (bus.req_addr[1:0]),
        .chk_misaligned (chk_misaligned),
        .size           (req_q.size),
        .sign_ext       (req_q.sign_ext),
        .addr_lo        (addr_q[1:0]),
        .wdata          (req_q.wdata),
        .rdata          (bus.mem_rdata),
        .b_en           (b_en),
        .wdata_rep      (wdata_rep),
        .rdata_fmt      (rdata_fmt)
    );

`ifdef RVM_MEM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Fires on the stalled edge that would complete TIMEOUT_CYCLES stalled cycles.
    assign to_hit = bus.mem_stall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn)
            to_cnt <= '0;
        else if (accept)
            to_cnt <= '0;
        else if (state == MEM_ST_BUS && bus.mem_stall)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        err_next      = err_q;
        accept        = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = chk_misaligned ? MEM_ST_FAULT : MEM_ST_BUS;
                end
            end
            MEM_ST_BUS: begin
                if (!bus.mem_stall) begin
                    state_next = MEM_ST_RESP;
                    err_next   = bus.mem_error ? MEM_ERR_BUS : MEM_ERR_NONE;
                end else if (to_hit) begin
                    state_next = MEM_ST_RESP;
                    err_next   = MEM_ERR_TIMEOUT;
                end
            end
            default: state_next = MEM_ST_IDLE;
        endcase
    end

    assign bus.mem_addr  = {addr_q[addr_w-1:2], 2'b00};
    assign bus.mem_wdata = wdata_rep;
    assign bus.mem_b_en  = (state == MEM_ST_BUS) ? b_en : '0;
    assign bus.mem_w_en  = (state == MEM_ST_BUS) && req_q.write;

    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            state               <= MEM_ST_IDLE;
            err_q               <= MEM_ERR_NONE;
            req_q               <= '0;
            addr_q              <= '0;
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.resp_error      <= 1'b0;
            bus.resp_misaligned <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
            if (accept) begin
                req_q.write    <= bus.req_write;
                req_q.size     <= bus.req_size;
                req_q.sign_ext <= bus.req_signed;
                req_q.wdata    <= bus.req_wdata;
                addr_q         <= bus.req_addr;
            end
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.resp_error      <= 1'b0;
            bus.resp_misaligned <= 1'b0;
            case (state)
                MEM_ST_RESP: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= (err_q != MEM_ERR_NONE);
                    if (err_q == MEM_ERR_NONE && !req_q.write)
                        bus.resp_rdata <= rdata_fmt;
                end
                MEM_ST_FAULT: begin
                    bus.resp_valid      <= 1'b1;
                    bus.resp_error      <= 1'b1;
                    bus.resp_misaligned <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: byte-array reference model predicts bus
// activity and responses per request; one negedge process compares every cycle.
module tb_mem_initiator;

    localparam int TO        = 16;
    localparam int MEM_BYTES = 256;

    logic gclk   = 1'b0;
    logic resetn = 1'b0;
    always #5 gclk = ~gclk;

    mem_initiator_if #(.addr_w(32)) bus ();

    mem_initiator #(.addr_w(32), .data_w(32), .TIMEOUT_CYCLES(TO)) dut (
        .gclk   (gclk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // SRAM responder: registered read, byte-lane writes, error above MEM_BYTES.
    logic [31:0] sram [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    assign bus.mem_error = (bus.mem_addr >= 32'(MEM_BYTES));

    always @(posedge gclk) begin
        if (poke_en)
            sram[poke_idx] <= poke_val;
        else if (bus.mem_b_en != 4'b0000 && !bus.mem_stall && !bus.mem_error) begin
            bus.mem_rdata <= sram[bus.mem_addr[7:2]];
            if (bus.mem_w_en)
                for (int i = 0; i < 4; i++)
                    if (bus.mem_b_en[i])
                        sram[bus.mem_addr[7:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Reference model: one record per accepted request, with its cycle schedule.
    typedef struct {
        int          acc;
        int          bus_last;
        int          resp;
        bit          mis;
        bit          wr;
        bit          err;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;

    logic [7:0] ref_mem [0:MEM_BYTES-1];
    txn_t       pend [$];

    task automatic model(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int stall_n, output txn_t t);
        int n;
        int base;
        bit to;
        logic [31:0] val;
        n      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        t.acc  = cyc + 1;
        t.wr   = wr;
        t.addr = {a[31:2], 2'b00};
        t.mis  = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        t.ben  = '0;
        t.wd   = '0;
        t.rd   = '0;
        for (int i = 0; i < n; i++)
            if (!t.mis) t.ben[int'(a[1:0]) + i] = 1'b1;
        for (int l = 0; l < 4; l++)
            t.wd[8*l +: 8] = wd[8*(l % n) +: 8];
`ifdef RVM_MEM_TIMEOUT_EN
        to = (stall_n >= TO);
`else
        to = 1'b0;
`endif
        if (t.mis) begin
            t.bus_last = t.acc - 1;
            t.resp     = t.acc + 1;
            t.err      = 1'b1;
        end else begin
            t.bus_last = to ? t.acc + TO - 1 : t.acc + stall_n;
            t.resp     = t.bus_last + 2;
            t.err      = to || (a >= 32'(MEM_BYTES));
            if (!t.err) begin
                base = int'(a[7:0]);
                if (wr) begin
                    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
                end else begin
                    val = '0;
                    for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[base + i];
                    if (sg)
                        for (int b = 8*n; b < 32; b++) val[b] = val[8*n-1];
                    t.rd = val;
                end
            end
        end
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the accept cycle.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int stall_n, output txn_t t);
        model(wr, sz, sg, a, wd, stall_n, t);
        pend.push_back(t);
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge gclk); #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_size   = 2'($urandom_range(0, 3));
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, input int stall_n, input bit pin_en,
                          input logic [31:0] p_rd, input logic [3:0] p_ben,
                          input logic [31:0] p_wd, input bit p_err);
        txn_t t;
        issue(wr, sz, sg, a, wd, stall_n, t);
        if (pin_en) begin
            check("pin_rd", t.rd, p_rd);
            check("pin_err", 32'(t.err), 32'(p_err));
            if (!t.mis) check("pin_ben", 32'(t.ben), 32'(p_ben));
            if (wr) check("pin_wd", t.wd, p_wd);
        end
        while (cyc < t.resp) begin
            bus.mem_stall = !t.mis && ((cyc - t.acc) < stall_n);
            @(posedge gclk); #1;
        end
        bus.mem_stall = 1'b0;
    endtask

    // Single compare process.
    always @(negedge gclk) begin : cmp
        txn_t t;
        bit   ready_e;
        bit   bus_e;
        bit   rv_e;
        if (!resetn) begin
            check("rst_ready", 32'(bus.req_ready), 32'd1);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("rst_resp_rdata", bus.resp_rdata, 32'd0);
            check("rst_resp_error", 32'({bus.resp_error, bus.resp_misaligned}), 32'd0);
            check("rst_b_en", 32'(bus.mem_b_en), 32'd0);
            check("rst_w_en", 32'(bus.mem_w_en), 32'd0);
            check("rst_mem_addr", bus.mem_addr, 32'd0);
            check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        end else begin
            ready_e = 1'b1;
            bus_e   = 1'b0;
            rv_e    = 1'b0;
            if (pend.size() > 0) begin
                t       = pend[0];
                ready_e = !(cyc >= t.acc && cyc < t.resp);
                bus_e   = !t.mis && cyc >= t.acc && cyc <= t.bus_last;
                rv_e    = (cyc == t.resp);
            end
            check("req_ready", 32'(bus.req_ready), 32'(ready_e));
            if (bus_e) begin
                check("mem_addr", bus.mem_addr, t.addr);
                check("mem_b_en", 32'(bus.mem_b_en), 32'(t.ben));
                check("mem_w_en", 32'(bus.mem_w_en), 32'(t.wr));
                if (t.wr) check("mem_wdata", bus.mem_wdata, t.wd);
            end else begin
                check("idle_b_en", 32'(bus.mem_b_en), 32'd0);
                check("idle_w_en", 32'(bus.mem_w_en), 32'd0);
            end
            check("resp_valid", 32'(bus.resp_valid), 32'(rv_e));
            if (rv_e) begin
                check("resp_rdata", bus.resp_rdata, t.rd);
                check("resp_error", 32'(bus.resp_error), 32'(t.err));
                check("resp_misaligned", 32'(bus.resp_misaligned), 32'(t.mis));
                void'(pend.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] w;
        txn_t        t;
        int          stall_n;
        logic [31:0] a;
        logic [1:0]  sz;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_stall  = 1'b0;
        poke_en        = 1'b0;
        poke_idx       = '0;
        poke_val       = '0;

        @(posedge gclk); #1;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (i == 4) w = 32'hDEADBEEF;
            if (i == 8) w = 32'h80000000;
            poke_idx = i[5:0];
            poke_val = w;
            poke_en  = 1'b1;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
            @(posedge gclk); #1;
        end
        poke_en = 1'b0;
        resetn  = 1'b1;
        @(posedge gclk); #1;

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'hA5, 0, 1'b1, 32'h0, 4'b1000, 32'hA5A5A5A5, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hA5ADBEEF, 4'hF, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 0, 1'b1, 32'hFFFFFF80, 4'b1000, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 0, 1'b1, 32'h00000080, 4'b1000, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1, 32'hA5ADBEEF, 4'hF, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
`ifdef RVM_MEM_TIMEOUT_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 20, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
`endif

        // Reset while the access is held in BUS: no response may follow.
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 10, t);
        bus.mem_stall = 1'b1;
        @(posedge gclk); #3;
        resetn = 1'b0;
        pend.delete();
        #1;
        check("async_rst_b_en", 32'(bus.mem_b_en), 32'd0);
        check("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge gclk);
        #3;
        resetn        = 1'b1;
        bus.mem_stall = 1'b0;
        repeat (6) @(posedge gclk);
        #1;

        for (int k = 0; k < 250; k++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h100 + $urandom_range(0, 255);
            else                           a = $urandom_range(0, MEM_BYTES - 1);
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1)      a[0]   = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            stall_n = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
            if ($urandom_range(0, 49) == 0) stall_n = 18;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, stall_n,
                   1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge gclk); #1;
            end
        end

        repeat (3) @(posedge gclk);
        #1;
        check("drain", 32'(pend.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
